conv_sched: RTL and testbench
=============================

# conv_sched

Sequencing controller for the convolution MAC datapath. On a start request it latches the feature-map size N, kernel size K and stride S, and computes the output size O = (N−K)/S + 1 with a serial divider. It then streams one (feature-map address, kernel address) pair per accepted beat, with accumulate-first/last tags, over every output window. It replaces free-running counter sequencing with an explicit start/busy/done handshake, a ready/valid read stream and configuration checking.

## Interface
Parameters:
- ADDR_W, 20, width of fm_addr / ker_addr
- DIM_W, 8, width of N, K, S, O and the loop counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- conv_i  in  DIM_W  feature-map side N (N×N)
- core_i  in  DIM_W  kernel side K (K×K)
- stride  in  DIM_W  stride S
- rd_ready  in  1  datapath accepts current beat
- rd_valid  out  1  fm_addr/ker_addr/tags valid
- fm_addr  out  ADDR_W  0-based row-major feature-map address
- ker_addr  out  ADDR_W  0-based row-major kernel address
- acc_first  out  1  first beat of a window (ky=kx=0)
- acc_last  out  1  last beat of a window (ky=kx=K−1)
- out_row, out_col  out  DIM_W  output coordinate of the current window
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  valid with done; run rejected

## Operation
- FSM states: IDLE, CALC, RUN, FIN.
- IDLE:
  - start=1 latches N, K, S and goes to CALC.
  - A later change of the config inputs has no effect on a run in progress.
- CALC:
  - First cycle checks the config. If K=0, S=0 or K>N: go to FIN with err=1, no beats issued.
  - Otherwise set rem=N−K, q=0.
  - Each cycle: if rem≥S then rem−=S, q++; else O=q+1 and go to RUN.
- RUN:
  - Loop order, outermost to innermost: out_row r, out_col c, ky, kx, each counting 0..O−1 or 0..K−1.
  - fm_addr = (r·S+ky)·N + c·S + kx.
  - ker_addr = ky·K + kx.
  - Addresses are built incrementally: base registers are advanced by adds (+1, +N, +S, +S·N). There are no runtime multipliers.
  - The loop advances only when rd_valid && rd_ready.
  - After the beat with r=c=O−1 and ky=kx=K−1 is accepted, go to FIN.
- FIN: done=1 for one cycle, cfg_err=err, then return to IDLE.
- start while busy: ignored.

## Timing
- Reset values: busy=0, done=0, cfg_err=0, rd_valid=0, fm_addr=0, ker_addr=0, acc_first=0, acc_last=0, out_row=0, out_col=0; FSM in IDLE.
- Latency from start to the first rd_valid: 1 (CALC check) + q+1 cycles, where q=(N−K)/S.
- In RUN, rd_valid stays high continuously. With rd_ready held high there is one beat per cycle, O²·K² beats in total.
- Backpressure: while rd_valid && !rd_ready, every output holds its value and the loop does not advance.
- done rises the cycle after the final beat is accepted; busy falls in that same cycle.
- cfg_err path: done asserts 2 cycles after start is accepted.
- rst asserted mid-run: all outputs go to reset values immediately. No done pulse is produced.
- Address arithmetic uses ADDR_W modulo 2^ADDR_W. Configurations with N² > 2^ADDR_W are unsupported and not checked.

## Structure
- Shared package conv_pkg holds:
  - the FSM state enum (IDLE/CALC/RUN/FIN)
  - DIM_W and ADDR_W defaults
  - localparam constants for the reset values
- One sub-module: conv_size_div, a serial repeated-subtraction divider with start/done. It returns O and the error flag to the FSM.
- The four-level loop counters and address bases stay inline in conv_sched.

## Test plan
- N=5, K=3, S=1, rd_ready=1:
  - O=3, 81 beats.
  - First fm_addr sequence: 0,1,2,5,6,7,10,11,12; ker_addr 0..8.
  - Second window starts at fm_addr 1. Final beat is fm_addr 24, ker_addr 8.
  - done rises exactly 1 cycle after the final beat.
- N=7, K=3, S=2:
  - O=3.
  - Window (r=1, c=0) starts at fm_addr 14. Window (0,1) starts at fm_addr 2.
  - acc_first/acc_last every 9 beats.
- Backpressure: N=5, K=3, S=1, rd_ready toggled randomly.
  - The address sequence is identical to the unstalled run.
  - Outputs are stable during every stalled cycle.
  - Beat count is 81.
- Config errors:
  - K=6, N=5: done and cfg_err pulse after 2 cycles, rd_valid never asserts.
  - The same holds for S=0.
- N=3, K=3, S=1: O=1, 9 beats (fm 0,1,2,3,4,5,6,7,8). A start pulsed mid-run is ignored.
- rst asserted at beat 40: all outputs are 0 in the same cycle. After a new start the run restarts from fm_addr 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution sequencing controller.
package conv_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DIM_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN,
        FIN
    } state_t;

    localparam logic        RST_FLAG = 1'b0;
    localparam int unsigned RST_ADDR = 0;
    localparam int unsigned RST_DIM  = 0;

endpackage

// File: rtl/conv_sched_if.sv
// Start/config request and ready/valid address stream between controller and MAC datapath.
interface conv_sched_if
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DIM_W  = DIM_W_DEF
);
    logic              start;
    logic [DIM_W-1:0]  conv_i;
    logic [DIM_W-1:0]  core_i;
    logic [DIM_W-1:0]  stride;
    logic              rd_ready;
    logic              rd_valid;
    logic [ADDR_W-1:0] fm_addr;
    logic [ADDR_W-1:0] ker_addr;
    logic              acc_first;
    logic              acc_last;
    logic [DIM_W-1:0]  out_row;
    logic [DIM_W-1:0]  out_col;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        output start, conv_i, core_i, stride, rd_ready,
        input  rd_valid, fm_addr, ker_addr, acc_first, acc_last,
               out_row, out_col, busy, done, cfg_err
    );

    modport slave (
        input  start, conv_i, core_i, stride, rd_ready,
        output rd_valid, fm_addr, ker_addr, acc_first, acc_last,
               out_row, out_col, busy, done, cfg_err
    );
endinterface

// File: rtl/conv_size_div.sv
// Serial repeated-subtraction divider: O = (N-K)/S + 1, with config rejection.
module conv_size_div
    import conv_pkg::*;
#(
    parameter int unsigned DIM_W = DIM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] n,
    input  logic [DIM_W-1:0] k,
    input  logic [DIM_W-1:0] s,
    output logic             done_c,
    output logic             err_c,
    output logic [DIM_W-1:0] o_c
);
    logic             active_r, active_n;
    logic             bad_r, bad_n;
    logic [DIM_W-1:0] rem_r, rem_n;
    logic [DIM_W-1:0] q_r, q_n;

    // Check cycle only records the verdict; the result is reported one cycle later
    always_comb begin
        active_n = active_r;
        bad_n    = bad_r;
        rem_n    = rem_r;
        q_n      = q_r;
        done_c   = 1'b0;
        err_c    = 1'b0;
        o_c      = q_r + DIM_W'(1);
        if (start) begin
            active_n = 1'b1;
            bad_n    = (k == '0) || (s == '0) || (k > n);
            rem_n    = n - k;
            q_n      = '0;
        end else if (active_r) begin
            if (bad_r) begin
                done_c   = 1'b1;
                err_c    = 1'b1;
                active_n = 1'b0;
            end else if (rem_r >= s) begin
                rem_n = rem_r - s;
                q_n   = q_r + DIM_W'(1);
            end else begin
                done_c   = 1'b1;
                active_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= RST_FLAG;
            bad_r    <= RST_FLAG;
            rem_r    <= DIM_W'(RST_DIM);
            q_r      <= DIM_W'(RST_DIM);
        end else begin
            active_r <= active_n;
            bad_r    <= bad_n;
            rem_r    <= rem_n;
            q_r      <= q_n;
        end
    end
endmodule

// File: rtl/conv_sched.sv
// Convolution MAC sequencer: sizes the output map, then streams fm/kernel address pairs per window.
module conv_sched
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DIM_W  = DIM_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    conv_sched_if.slave bus
);
    state_t            state, state_n;
    logic [DIM_W-1:0]  n_r, n_n, k_r, k_n, s_r, s_n, o_r, o_n;
    logic [DIM_W-1:0]  kx_r, kx_n, ky_r, ky_n, row_r, row_n, col_r, col_n;
    logic [ADDR_W-1:0] sn_r, sn_n, line_r, line_n, win_r, win_n, rbase_r, rbase_n;
    logic [ADDR_W-1:0] fm_r, fm_n, ker_r, ker_n;
    logic              calc_first_r, calc_first_n;
    logic              valid_r, valid_n, af_r, af_n, al_r, al_n;
    logic              busy_r, busy_n, done_r, done_n, err_r, err_n;
    logic              div_done, div_err;
    logic [DIM_W-1:0]  div_o;
    logic              end_kx, end_ky, end_col, end_row;

    conv_size_div #(.DIM_W(DIM_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (calc_first_r),
        .n      (n_r),
        .k      (k_r),
        .s      (s_r),
        .done_c (div_done),
        .err_c  (div_err),
        .o_c    (div_o)
    );

    assign end_kx  = (kx_r  == k_r - DIM_W'(1));
    assign end_ky  = (ky_r  == k_r - DIM_W'(1));
    assign end_col = (col_r == o_r - DIM_W'(1));
    assign end_row = (row_r == o_r - DIM_W'(1));

    always_comb begin
        state_n      = state;
        n_n = n_r;  k_n = k_r;  s_n = s_r;  o_n = o_r;
        kx_n = kx_r;  ky_n = ky_r;  row_n = row_r;  col_n = col_r;
        sn_n = sn_r;  line_n = line_r;  win_n = win_r;  rbase_n = rbase_r;
        fm_n = fm_r;  ker_n = ker_r;
        calc_first_n = 1'b0;
        valid_n = valid_r;  af_n = af_r;  al_n = al_r;
        busy_n = busy_r;  done_n = 1'b0;  err_n = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                n_n          = bus.conv_i;
                k_n          = bus.core_i;
                s_n          = bus.stride;
                calc_first_n = 1'b1;
                busy_n       = 1'b1;
                state_n      = CALC;
            end
            CALC: begin
                // One-time row-stride product per run; all address stepping below is adds only
                if (calc_first_r) sn_n = ADDR_W'(s_r) * ADDR_W'(n_r);
                if (div_done) begin
                    if (div_err) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        state_n = FIN;
                    end else begin
                        o_n = div_o;
                        kx_n = '0;  ky_n = '0;  row_n = '0;  col_n = '0;
                        line_n = '0;  win_n = '0;  rbase_n = '0;  fm_n = '0;  ker_n = '0;
                        valid_n = 1'b1;
                        af_n    = 1'b1;
                        al_n    = (k_r == DIM_W'(1));
                        state_n = RUN;
                    end
                end
            end
            RUN: if (bus.rd_ready) begin
                if (!end_kx) begin
                    kx_n  = kx_r + DIM_W'(1);
                    fm_n  = fm_r + ADDR_W'(1);
                    ker_n = ker_r + ADDR_W'(1);
                end else if (!end_ky) begin
                    kx_n   = '0;
                    ky_n   = ky_r + DIM_W'(1);
                    line_n = line_r + ADDR_W'(n_r);
                    fm_n   = line_r + ADDR_W'(n_r);
                    ker_n  = ker_r + ADDR_W'(1);
                end else if (!end_col) begin
                    kx_n   = '0;
                    ky_n   = '0;
                    col_n  = col_r + DIM_W'(1);
                    win_n  = win_r + ADDR_W'(s_r);
                    line_n = win_r + ADDR_W'(s_r);
                    fm_n   = win_r + ADDR_W'(s_r);
                    ker_n  = '0;
                end else if (!end_row) begin
                    kx_n    = '0;
                    ky_n    = '0;
                    col_n   = '0;
                    row_n   = row_r + DIM_W'(1);
                    rbase_n = rbase_r + sn_r;
                    win_n   = rbase_r + sn_r;
                    line_n  = rbase_r + sn_r;
                    fm_n    = rbase_r + sn_r;
                    ker_n   = '0;
                end else begin
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = FIN;
                end
                if (state_n == RUN) begin
                    af_n = (kx_n == '0) && (ky_n == '0);
                    al_n = (kx_n == k_r - DIM_W'(1)) && (ky_n == k_r - DIM_W'(1));
                end else begin
                    af_n = 1'b0;
                    al_n = 1'b0;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            n_r <= '0;  k_r <= '0;  s_r <= '0;  o_r <= '0;
            kx_r <= '0;  ky_r <= '0;
            row_r <= DIM_W'(RST_DIM);  col_r <= DIM_W'(RST_DIM);
            sn_r <= '0;  line_r <= '0;  win_r <= '0;  rbase_r <= '0;
            fm_r <= ADDR_W'(RST_ADDR);  ker_r <= ADDR_W'(RST_ADDR);
            calc_first_r <= RST_FLAG;
            valid_r <= RST_FLAG;  af_r <= RST_FLAG;  al_r <= RST_FLAG;
            busy_r <= RST_FLAG;  done_r <= RST_FLAG;  err_r <= RST_FLAG;
        end else begin
            state <= state_n;
            n_r <= n_n;  k_r <= k_n;  s_r <= s_n;  o_r <= o_n;
            kx_r <= kx_n;  ky_r <= ky_n;  row_r <= row_n;  col_r <= col_n;
            sn_r <= sn_n;  line_r <= line_n;  win_r <= win_n;  rbase_r <= rbase_n;
            fm_r <= fm_n;  ker_r <= ker_n;
            calc_first_r <= calc_first_n;
            valid_r <= valid_n;  af_r <= af_n;  al_r <= al_n;
            busy_r <= busy_n;  done_r <= done_n;  err_r <= err_n;
        end
    end

    assign bus.rd_valid  = valid_r;
    assign bus.fm_addr   = fm_r;
    assign bus.ker_addr  = ker_r;
    assign bus.acc_first = af_r;
    assign bus.acc_last  = al_r;
    assign bus.out_row   = row_r;
    assign bus.out_col   = col_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.cfg_err   = err_r;
endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: address streams, tags, backpressure, config errors and mid-run reset.
module tb_conv_sched;
    import conv_pkg::*;

    localparam int unsigned AW = ADDR_W_DEF;
    localparam int unsigned DW = DIM_W_DEF;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   beats, last_fm, last_ker, first_cnt, last_cnt;
    int   win_start [4][4];
    int   seq_fm [9];
    int   exp_a [9];
    int   exp_b [9];

    conv_sched_if #(.ADDR_W(AW), .DIM_W(DW)) bus ();
    conv_sched #(.ADDR_W(AW), .DIM_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_rd_valid"},  32'(bus.rd_valid), 0);
        check({tag, "_fm_addr"},   32'(bus.fm_addr), 0);
        check({tag, "_ker_addr"},  32'(bus.ker_addr), 0);
        check({tag, "_acc_first"}, 32'(bus.acc_first), 0);
        check({tag, "_acc_last"},  32'(bus.acc_last), 0);
        check({tag, "_out_row"},   32'(bus.out_row), 0);
        check({tag, "_out_col"},   32'(bus.out_col), 0);
        check({tag, "_busy"},      32'(bus.busy), 0);
        check({tag, "_done"},      32'(bus.done), 0);
        check({tag, "_cfg_err"},   32'(bus.cfg_err), 0);
    endtask

    task automatic do_run(input int n, input int k, input int s, input bit rnd,
                          input int abort_at, input int poke_at);
        int q, o, lat, idx, stalls, efm, eker;
        bit rdy;
        q = (n - k) / s;
        o = q + 1;
        lat = 0;
        idx = 0;
        beats = 0; first_cnt = 0; last_cnt = 0; last_fm = -1; last_ker = -1;
        bus.conv_i = DW'(n); bus.core_i = DW'(k); bus.stride = DW'(s); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.conv_i = DW'(9); bus.core_i = DW'(1); bus.stride = DW'(4);
        check("busy_rise", 32'(bus.busy), 1);
        while (bus.rd_valid !== 1'b1 && lat < 600) begin
            tick();
            lat++;
        end
        check("first_valid_lat", lat, q + 2);
        for (int r = 0; r < o; r++)
            for (int c = 0; c < o; c++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        efm    = (r * s + ky) * n + c * s + kx;
                        eker   = ky * k + kx;
                        stalls = 0;
                        do begin
                            if (idx == abort_at) begin
                                rst = 1'b1;
                                #1;
                                chk_zero("rst_mid");
                                beats = idx;
                                return;
                            end
                            rdy = (rnd && stalls < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                            bus.rd_ready = rdy;
                            if (idx == poke_at && stalls == 0) begin
                                bus.start = 1'b1;
                                bus.conv_i = DW'(5); bus.core_i = DW'(2); bus.stride = DW'(1);
                            end
                            check("rd_valid",  32'(bus.rd_valid), 1);
                            check("fm_addr",   32'(bus.fm_addr), efm);
                            check("ker_addr",  32'(bus.ker_addr), eker);
                            check("acc_first", 32'(bus.acc_first), 32'(kx == 0 && ky == 0));
                            check("acc_last",  32'(bus.acc_last), 32'(kx == k - 1 && ky == k - 1));
                            check("out_row",   32'(bus.out_row), r);
                            check("out_col",   32'(bus.out_col), c);
                            check("busy_run",  32'(bus.busy), 1);
                            check("done_run",  32'(bus.done), 0);
                            if (kx == 0 && ky == 0 && r < 4 && c < 4) win_start[r][c] = int'(bus.fm_addr);
                            if (idx < 9) seq_fm[idx] = int'(bus.fm_addr);
                            last_fm  = int'(bus.fm_addr);
                            last_ker = int'(bus.ker_addr);
                            if (rdy) begin
                                first_cnt += int'(bus.acc_first);
                                last_cnt  += int'(bus.acc_last);
                            end
                            tick();
                            bus.start = 1'b0;
                            stalls++;
                        end while (!rdy);
                        idx++;
                    end
        beats = idx;
        check("done_rise",  32'(bus.done), 1);
        check("done_err",   32'(bus.cfg_err), 0);
        check("busy_fall",  32'(bus.busy), 0);
        check("valid_fall", 32'(bus.rd_valid), 0);
        bus.rd_ready = 1'b0;
        tick();
        check("done_pulse", 32'(bus.done), 0);
    endtask

    task automatic do_err(input int n, input int k, input int s);
        bus.conv_i = DW'(n); bus.core_i = DW'(k); bus.stride = DW'(s); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("err_busy",        32'(bus.busy), 1);
        check("err_done_early",  32'(bus.done), 0);
        tick();
        check("err_done_wait",   32'(bus.done), 0);
        check("err_valid_wait",  32'(bus.rd_valid), 0);
        tick();
        check("err_done",        32'(bus.done), 1);
        check("err_flag",        32'(bus.cfg_err), 1);
        check("err_busy_fall",   32'(bus.busy), 0);
        check("err_valid",       32'(bus.rd_valid), 0);
        tick();
        check("err_done_pulse",  32'(bus.done), 0);
        check("err_flag_pulse",  32'(bus.cfg_err), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.conv_i = '0; bus.core_i = '0; bus.stride = '0; bus.rd_ready = 1'b0;
        exp_a = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        exp_b = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        do_run(5, 3, 1, 1'b0, -1, -1);
        check("n5_beats", beats, 81);
        for (int i = 0; i < 9; i++) check("n5_first_window", seq_fm[i], exp_a[i]);
        check("n5_win01", win_start[0][1], 1);
        check("n5_last_fm", last_fm, 24);
        check("n5_last_ker", last_ker, 8);
        check("n5_first_tags", first_cnt, 9);
        check("n5_last_tags", last_cnt, 9);

        do_run(7, 3, 2, 1'b0, -1, -1);
        check("n7_beats", beats, 81);
        check("n7_win10", win_start[1][0], 14);
        check("n7_win01", win_start[0][1], 2);
        check("n7_win22", win_start[2][2], 32);
        check("n7_first_tags", first_cnt, 9);
        check("n7_last_tags", last_cnt, 9);

        do_run(5, 3, 1, 1'b1, -1, -1);
        check("bp_beats", beats, 81);
        for (int i = 0; i < 9; i++) check("bp_first_window", seq_fm[i], exp_a[i]);
        check("bp_last_fm", last_fm, 24);

        do_err(5, 6, 1);
        do_err(5, 3, 0);
        do_err(5, 0, 1);

        do_run(3, 3, 1, 1'b0, -1, 4);
        check("n3_beats", beats, 9);
        for (int i = 0; i < 9; i++) check("n3_seq", seq_fm[i], exp_b[i]);
        repeat (3) tick();
        check("n3_idle_busy", 32'(bus.busy), 0);
        check("n3_idle_valid", 32'(bus.rd_valid), 0);

        do_run(5, 3, 1, 1'b0, 40, -1);
        check("abort_beats", beats, 40);
        tick();
        rst = 1'b0;
        tick();
        chk_zero("post_rst");
        do_run(5, 3, 1, 1'b0, -1, -1);
        check("restart_beats", beats, 81);
        check("restart_fm0", seq_fm[0], 0);
        check("restart_fm3", seq_fm[3], 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
